// File: rtl/dram_arbiter.sv
// ---------------------------------------------------------------------------
// dram_arbiter
//   Two-master arbiter in front of the single-port data RAM. Master 0 is the
//   CPU data port, master 1 is a secondary bus master (DMA / debug loader).
//   One master is granted per cycle. Arbitration is round-robin with a bounded
//   burst length. The granted master's command is muxed onto the RAM, and read
//   data plus ack are returned to that master.
//
//   Optional build macro: DRAM_ARB_FIXED_PRIO_EN
//     When defined, m0 has strict priority: any m0_req moves the grant to m0,
//     m0 keeps it for as long as it requests, and m1 is served only while m0 is
//     idle. The burst counter and last-granted tracking are then inert.
//
// Ports
//   clk, rst         : clock (rising edge), asynchronous active-low reset
//   m0_* / m1_*      : master request ports (req, we, addr, sel, wdata in;
//                      rdata, ack out); m0_stall is the CPU stall request
//   ram_*            : RAM command outputs, ram_rdata is a combinational read
//   gnt_id           : 00 idle, 01 m0 granted, 10 m1 granted
//   dbg_state        : current FSM state (same encoding as gnt_id)
//
// Handshake: a master raises req with a command and holds both stable until it
// sees ack. ack is high in each cycle that completes a transfer, so a master
// that keeps req high issues one transfer per granted cycle. The arbiter does
// not latch commands; it forwards the live command of the granted master.
// ---------------------------------------------------------------------------
module dram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_sel,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_stall,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_sel,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        gnt_id,
  output logic [1:0]        dbg_state
);

  // State encoding doubles as the gnt_id value.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  // Highest burst count value; reaching it with the other master waiting
  // hands the grant over.
  localparam logic [3:0] CNT_MAX = 4'(BURST_LEN - 1);

  state_e     state_q, state_d;
  logic       last_q,  last_d;   // last granted master (1 = m1)
  logic [3:0] cnt_q,   cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;           // m0 wins the first tie
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
`ifdef DRAM_ARB_FIXED_PRIO_EN
    case (state_q)
      IDLE, GNT1: begin
        if (m0_req)      state_d = GNT0;
        else if (m1_req) state_d = GNT1;
        else             state_d = IDLE;
      end
      GNT0: begin
        if (m0_req)      state_d = GNT0;
        else if (m1_req) state_d = GNT1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`else
    case (state_q)
      IDLE: begin
        // On a tie the master that was not granted last goes first.
        if (m0_req && (!m1_req || last_q)) begin
          state_d = GNT0;
          cnt_d   = 4'd0;
          last_d  = 1'b0;
        end else if (m1_req) begin
          state_d = GNT1;
          cnt_d   = 4'd0;
          last_d  = 1'b1;
        end
      end
      GNT0: begin
        if (m0_req && (!m1_req || cnt_q < CNT_MAX)) begin
          // Count saturates at CNT_MAX while m0 runs alone, so a late m1
          // request can take over on the next edge.
          if (cnt_q < CNT_MAX) cnt_d = cnt_q + 4'd1;
        end else if (m1_req) begin
          state_d = GNT1;
          cnt_d   = 4'd0;
          last_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        if (m1_req && (!m0_req || cnt_q < CNT_MAX)) begin
          if (cnt_q < CNT_MAX) cnt_d = cnt_q + 4'd1;
        end else if (m0_req) begin
          state_d = GNT0;
          cnt_d   = 4'd0;
          last_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`endif
  end

  // Output mux, combinational from state and live requests. A granted master
  // that has dropped req gets a dead cycle: no chip enable, no ack.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = 4'b0000;
    ram_wdata = '0;
    m0_ack    = 1'b0;
    m0_rdata  = '0;
    m1_ack    = 1'b0;
    m1_rdata  = '0;
    case (state_q)
      GNT0: begin
        ram_ce    = m0_req;
        ram_we    = m0_req & m0_we;   // never write without chip enable
        ram_addr  = m0_addr;
        ram_sel   = m0_sel;
        ram_wdata = m0_wdata;
        m0_ack    = m0_req;
        m0_rdata  = ram_rdata;
      end
      GNT1: begin
        ram_ce    = m1_req;
        ram_we    = m1_req & m1_we;
        ram_addr  = m1_addr;
        ram_sel   = m1_sel;
        ram_wdata = m1_wdata;
        m1_ack    = m1_req;
        m1_rdata  = ram_rdata;
      end
      default: ;
    endcase
  end

  assign m0_stall  = m0_req & ~m0_ack;
  assign gnt_id    = state_q;
  assign dbg_state = state_q;

endmodule
